// File: rtl/cla_seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial-product add per clock through
// a carry-lookahead adder, full 2*WIDTH product delivered over a valid/ready handshake.

module carry_lookahead_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-2:0] g_s;
  logic [WIDTH-1:0] c_s;
  logic [NG-1:0]    gc_s;

  assign p_s     = a ^ b;
  assign g_s     = a[WIDTH-2:0] & b[WIDTH-2:0];
  assign gc_s[0] = c_in;

  // 4-bit lookahead groups; group generate/propagate ripple between groups.
  // The final carry-out is not formed here: the multiplier derives it from S.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c_s[B]   = gc_s[k];
    assign c_s[B+1] = g_s[B] | (p_s[B] & gc_s[k]);
    assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & gc_s[k]);
    assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                    | (p_s[B+2] & p_s[B+1] & p_s[B] & gc_s[k]);
    if (k < NG - 1) begin : g_next
      logic grp_g_s;
      logic grp_p_s;
      assign grp_g_s = g_s[B+3] | (p_s[B+3] & g_s[B+2]) | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                     | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
      assign grp_p_s = &p_s[B+3:B];
      assign gc_s[k+1] = grp_g_s | (grp_p_s & gc_s[k]);
    end
  end

  assign s = p_s ^ c_s;
endmodule

module cla_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] add_b_s;
  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             last_step_s;

  assign add_b_s = lo_r[0] ? mcand_r : {WIDTH{1'b0}};

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (hi_r),
    .b    (add_b_s),
    .c_in (1'b0),
    .s    (sum_s)
  );

  // Adder exposes only S; recover its carry-out from the operand and sum MSBs.
  assign carry_s = (hi_r[WIDTH-1] & add_b_s[WIDTH-1])
                 | ((hi_r[WIDTH-1] | add_b_s[WIDTH-1]) & ~sum_s[WIDTH-1]);
  assign last_step_s = (count_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, shift-add datapath and registered product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r   <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      out_p     <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_r <= in_a;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= in_b;
            count_r <= {CNT_W{1'b0}};
          end
        end
        ST_CALC: begin
          hi_r    <= {carry_s, sum_s[WIDTH-1:1]};
          lo_r    <= {sum_s[0], lo_r[WIDTH-1:1]};
          count_r <= count_r + CNT_W'(1);
          if (last_step_s) begin
            out_valid <= 1'b1;
            out_p     <= {carry_s, sum_s, lo_r[WIDTH-1:1]};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_multiplier.sv
// Self-checking bench for cla_seq_multiplier: directed literal cases plus random
// back-to-back operations checked every cycle against a behavioural timing/product model.

module tb_cla_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int acc_cyc = 0;
  int lat = 0;
  logic rnd_mode = 1'b0;
  logic rnd_stall = 1'b0;

  // model state
  logic m_armed = 1'b0;
  logic m_valid = 1'b0;
  logic m_ready = 1'b1;
  logic m_busy = 1'b0;
  int   m_steps = 0;
  logic [63:0] exp_q[$];

  cla_seq_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model with the
  // inputs the DUT will see at the coming rising edge.
  always @(negedge clk) begin
    if (m_armed) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
      if (m_valid && exp_q.size() > 0) chk("out_p", out_p, exp_q[0]);
    end
    if (rst) begin
      m_armed = 1'b1;
      m_valid = 1'b0;
      m_ready = 1'b1;
      m_busy  = 1'b0;
      exp_q.delete();
    end else if (m_ready && in_valid) begin
      exp_q.push_back({32'd0, in_a} * {32'd0, in_b});
      m_ready = 1'b0;
      m_busy  = 1'b1;
      m_steps = 32;
    end else if (m_busy) begin
      m_steps--;
      if (m_steps == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
      void'(exp_q.pop_front());
      n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rnd_stall) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      step();
    end
    chk("accept", {63'd0, acc}, 64'd1);
    if (acc) begin
      acc_cyc = cyc;
      n_acc++;
    end
    if (!rnd_mode) begin
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
    end
  endtask

  task automatic wait_result(input string nm, input logic [63:0] exp);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk({nm, "_seen"}, {63'd0, seen}, 64'd1);
    if (seen) chk(nm, out_p, exp);
    lat = cyc - acc_cyc;
  endtask

  initial begin
    logic [63:0] p0;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = 32'd0;
    in_b = 32'd0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_p", out_p, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // zero multiplicand, exact latency
    out_ready = 1'b1;
    do_op(32'd0, 32'hDEAD_BEEF);
    wait_result("zero", 64'd0);
    chk("latency", 64'(lat), 64'd32);
    step();

    do_op(32'd3, 32'd5);
    @(negedge clk);
    chk("calc_in_ready", {63'd0, in_ready}, 64'd0);
    wait_result("three_five", 64'h0000_0000_0000_000F);
    step();

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("all_ones", 64'hFFFF_FFFE_0000_0001);
    step();

    // hold product under backpressure
    out_ready = 1'b0;
    do_op(32'd100000, 32'd300000);
    wait_result("stall", 64'h0000_0006_FC23_AC00);
    p0 = out_p;
    repeat (10) step();
    @(negedge clk);
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_p", out_p, p0);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    step();

    // reset in the middle of a calculation
    do_op(32'd7, 32'd9);
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();
    do_op(32'd2, 32'd3);
    wait_result("after_rst", 64'd6);
    step();

    // random back-to-back operations with random output stalls
    rnd_mode = 1'b1;
    rnd_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'd0;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op(ra, rb);
    end
    in_valid = 1'b0;
    rnd_mode = 1'b0;
    rnd_stall = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();
    chk("ops_done", 64'(n_done), 64'(n_acc - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
